// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IFU) and load/store (LSU).
// One transaction in flight at a time; the grant is held until the response or a timeout abort.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                timeout_err,
  output logic                busy
);

  localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);
  localparam bit               TO_EN      = (TIMEOUT > 0);
  localparam logic [3:0]       SL         = 4'(STARVE_LIMIT);
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t           state;
  state_t           state_next;
  logic             owner_lsu;
  logic [3:0]       starve_cnt;
  logic [CNT_W-1:0] to_cnt;
  logic             grant_ifu;
  logic             grant_lsu;
  logic             accept;
  logic             rsp_done;
  logic             to_hit;

  // Handshake: a requester's valid/address are held until its req_ready is seen high;
  // req_ready is only ever high in IDLE, and rsp_valid pulses are never back-pressured.
  always_comb begin
    state_next    = state;
    grant_lsu     = lsu_req_valid && !(ifu_req_valid && (starve_cnt == SL));
    grant_ifu     = ifu_req_valid && !grant_lsu;
    ifu_req_ready = (state == IDLE) && grant_ifu && !rst;
    lsu_req_ready = (state == IDLE) && grant_lsu && !rst;
    accept        = ifu_req_ready || lsu_req_ready;
    rsp_done      = (state == WAIT_RSP) && mem_rsp_valid;
    // A real response arriving on the deadline cycle beats the abort.
    to_hit        = TO_EN && (state != IDLE) && (to_cnt == TO_VAL) && !rsp_done;
    case (state)
      IDLE:     if (accept) state_next = REQ;
      REQ:      if (to_hit) state_next = IDLE;
                else if (mem_req_ready) state_next = WAIT_RSP;
      WAIT_RSP: if (rsp_done || to_hit) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign mem_req_valid = (state == REQ);
  assign busy          = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_lsu     <= 1'b0;
      starve_cnt    <= '0;
      to_cnt        <= '0;
      mem_addr      <= '0;
      mem_wen       <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
      ifu_rsp_valid <= 1'b0;
      ifu_rdata     <= '0;
      lsu_rsp_valid <= 1'b0;
      lsu_rdata     <= '0;
      timeout_err   <= 1'b0;
    end else begin
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
      timeout_err   <= 1'b0;
      if (accept) begin
        owner_lsu <= lsu_req_ready;
        to_cnt    <= '0;
        mem_addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
        mem_wen   <= lsu_req_ready && lsu_wen;
        mem_wdata <= lsu_req_ready ? lsu_wdata : '0;
        mem_wmask <= lsu_req_ready ? lsu_wmask : '0;
        if (ifu_req_ready) starve_cnt <= '0;
        else if (ifu_req_valid && (starve_cnt != SL)) starve_cnt <= starve_cnt + 4'd1;
      end else if (state != IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (rsp_done || to_hit) begin
        timeout_err <= to_hit;
        if (owner_lsu) begin
          lsu_rsp_valid <= 1'b1;
          lsu_rdata     <= rsp_done ? mem_rdata : ABORT_DATA;
        end else begin
          ifu_rsp_valid <= 1'b1;
          ifu_rdata     <= rsp_done ? mem_rdata : ABORT_DATA;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int SL = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0, ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready;
  logic [31:0] lsu_addr = '0;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_wdata = '0;
  logic [3:0]  lsu_wmask = '0;
  logic        lsu_rsp_valid;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        timeout_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err), .busy(busy)
  );

  // Clock / reset: 10-unit period; inputs change on the falling edge.
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: at most one transaction record in flight.
  bit          m_active = 0, m_issued = 0, m_owner_lsu = 0;
  int          m_age = 0, m_starve = 0;
  logic [31:0] m_addr = '0, m_wdata = '0;
  logic        m_wen = 0;
  logic [3:0]  m_wmask = '0;
  logic        m_ifu_rsp = 0, m_lsu_rsp = 0, m_to = 0;
  logic [31:0] m_ifu_rdata = '0, m_lsu_rdata = '0;
  bit          m_last_ifu_acc = 0, m_last_lsu_acc = 0;

  function automatic bit ifu_wins();
    return ifu_req_valid && (!lsu_req_valid || m_starve == SL);
  endfunction

  task automatic model_finish(input logic [31:0] d, input logic t);
    m_active = 0;
    m_to     = t;
    if (m_owner_lsu) begin m_lsu_rsp = 1; m_lsu_rdata = d; end
    else begin m_ifu_rsp = 1; m_ifu_rdata = d; end
  endtask

  task automatic model_step();
    bit iw, lw;
    iw = ifu_wins();
    lw = lsu_req_valid && !iw;
    m_last_ifu_acc = 0;
    m_last_lsu_acc = 0;
    m_ifu_rsp = 0; m_lsu_rsp = 0; m_to = 0;
    if (rst) begin
      m_active = 0; m_issued = 0; m_owner_lsu = 0; m_age = 0; m_starve = 0;
      m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
      m_ifu_rdata = '0; m_lsu_rdata = '0;
    end else if (m_active) begin
      if (m_issued && mem_rsp_valid) model_finish(mem_rdata, 1'b0);
      else if (m_age == TO) model_finish(32'hDEADBEEF, 1'b1);
      else begin
        if (!m_issued && mem_req_ready) m_issued = 1;
        m_age++;
      end
    end else if (iw || lw) begin
      m_active = 1; m_issued = 0; m_age = 0; m_owner_lsu = lw;
      m_addr  = lw ? lsu_addr : ifu_addr;
      m_wen   = lw && lsu_wen;
      m_wdata = lw ? lsu_wdata : 32'h0;
      m_wmask = lw ? lsu_wmask : 4'h0;
      m_last_ifu_acc = iw;
      m_last_lsu_acc = lw;
      if (iw) m_starve = 0;
      else if (ifu_req_valid && m_starve < SL) m_starve++;
    end
  endtask

  // Compare process: every non-reset cycle, after inputs settle, then advance the model.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("ifu_req_ready", ifu_req_ready, !m_active && ifu_wins());
      chk("lsu_req_ready", lsu_req_ready, !m_active && lsu_req_valid && !ifu_wins());
      chk("mem_req_valid", mem_req_valid, m_active && !m_issued);
      chk("busy", busy, m_active);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_wdata", mem_wdata, m_wdata);
      chk("mem_wmask", mem_wmask, m_wmask);
      chk("ifu_rsp_valid", ifu_rsp_valid, m_ifu_rsp);
      chk("ifu_rdata", ifu_rdata, m_ifu_rdata);
      chk("lsu_rsp_valid", lsu_rsp_valid, m_lsu_rsp);
      chk("lsu_rdata", lsu_rdata, m_lsu_rdata);
      chk("timeout_err", timeout_err, m_to);
    end
    model_step();
  end

  // Memory responder. Modes: 0 zero-wait, 1 random, 2 accept but never respond, 3 never ready.
  int          mem_mode = 0;
  logic [31:0] mem_fixed = 32'h13;
  bit          force_rsp = 0;
  int          rsp_wait = 0;

  always @(negedge clk) begin
    #1;
    mem_req_ready = 1'b0;
    mem_rsp_valid = force_rsp;
    mem_rdata     = mem_fixed;
    case (mem_mode)
      0: begin
        mem_req_ready = 1'b1;
        if (m_active && m_issued) mem_rsp_valid = 1'b1;
      end
      1: begin
        mem_rdata     = $urandom;
        mem_req_ready = ($urandom_range(0, 2) != 0);
        if (m_active && m_issued) begin
          if (rsp_wait == 0) mem_rsp_valid = 1'b1;
          else rsp_wait--;
        end else begin
          rsp_wait = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 9));
          if ($urandom_range(0, 9) == 0) mem_rsp_valid = 1'b1;
        end
      end
      2: mem_req_ready = 1'b1;
      default: ;
    endcase
  end

  // Driver tasks.
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      nxt();
      ifu_req_valid = 0;
      lsu_req_valid = 0;
    end
  endtask

  task automatic drive_random(input bit allow_new);
    if (!(ifu_req_valid && !m_last_ifu_acc)) begin
      ifu_req_valid = allow_new && ($urandom_range(0, 2) != 0);
      ifu_addr      = $urandom & 32'hFFFF_FFFC;
    end
    if (!(lsu_req_valid && !m_last_lsu_acc)) begin
      lsu_req_valid = allow_new && ($urandom_range(0, 2) != 0);
      lsu_addr      = $urandom & 32'hFFFF_FFFC;
      lsu_wen       = $urandom_range(0, 1);
      lsu_wdata     = $urandom;
      lsu_wmask     = 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    int n;
    int k;
    logic [5:0] seq;

    repeat (3) nxt();
    rst = 0;
    #3;
    chk("reset busy", busy, 0);
    chk("reset mem_req_valid", mem_req_valid, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset lsu_rdata", lsu_rdata, 0);
    idle(1);

    // IFU alone, zero-wait memory.
    nxt();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
    #3 chk("t1 ifu_req_ready@T", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0;
    #3 chk("t1 mem_req_valid@T+1", mem_req_valid, 1);
    chk("t1 mem_wen@T+1", mem_wen, 0);
    chk("t1 mem_addr@T+1", mem_addr, 32'h8000_0000);
    nxt();
    #3 chk("t1 mem_req_valid@T+2", mem_req_valid, 0);
    nxt();
    #3 chk("t1 ifu_rsp_valid@T+3", ifu_rsp_valid, 1);
    chk("t1 ifu_rdata@T+3", ifu_rdata, 32'h13);
    chk("t1 lsu_rsp_valid@T+3", lsu_rsp_valid, 0);
    idle(2);

    // Simultaneous IFU fetch and LSU store.
    nxt();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    lsu_req_valid = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1;
    lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'hF;
    #3 chk("t2 lsu_req_ready", lsu_req_ready, 1);
    chk("t2 ifu_req_ready", ifu_req_ready, 0);
    nxt(); lsu_req_valid = 0;
    #3 chk("t2 mem_wen", mem_wen, 1);
    chk("t2 mem_wmask", mem_wmask, 4'hF);
    chk("t2 mem_wdata", mem_wdata, 32'hCAFE_F00D);
    nxt();
    nxt();
    #3 chk("t2 lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("t2 ifu granted next", ifu_req_ready, 1);
    idle(4);

    // Starvation: both held valid; expect L L L L I L.
    n = 0; seq = '0;
    lsu_wen = 0; lsu_addr = 32'h8000_0200;
    for (int c = 0; c < 60 && n < 6; c++) begin
      nxt();
      ifu_req_valid = 1; lsu_req_valid = 1;
      #3;
      if (ifu_req_ready) begin seq[n] = 1'b1; n++; end
      else if (lsu_req_ready) begin seq[n] = 1'b0; n++; end
    end
    chk("t3 grant count", n, 6);
    chk("t3 grant order", {26'd0, seq}, 32'b010000);
    idle(4);

    // Timeout with a memory that never responds.
    mem_mode = 2;
    nxt();
    lsu_req_valid = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0;
    #3 chk("t4 lsu_req_ready", lsu_req_ready, 1);
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      nxt(); lsu_req_valid = 0;
      #3;
      if (timeout_err) begin k = c; break; end
    end
    chk("t4 timeout latency", k, 10);
    chk("t4 lsu_rsp_valid", lsu_rsp_valid, 1);
    chk("t4 lsu_rdata", lsu_rdata, 32'hDEADBEEF);
    chk("t4 ifu_rsp_valid", ifu_rsp_valid, 0);
    nxt();
    #3 chk("t4 busy after", busy, 0);
    nxt(); force_rsp = 1;
    nxt(); force_rsp = 0;
    #3 chk("t4 stray rsp ignored", lsu_rsp_valid, 0);
    chk("t4 stray busy", busy, 0);

    // Backpressure: mem_req_ready low for five cycles.
    mem_mode = 3;
    nxt();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
    #3 chk("t5 ifu_req_ready", ifu_req_ready, 1);
    for (int c = 0; c < 5; c++) begin
      nxt();
      ifu_req_valid = 0;
      lsu_req_valid = 1; lsu_addr = 32'h8000_0400; lsu_wen = 1;
      lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3;
      #3 chk("t5 mem_req_valid", mem_req_valid, 1);
      chk("t5 mem_addr", mem_addr, 32'h8000_0040);
      chk("t5 ifu_req_ready", ifu_req_ready, 0);
      chk("t5 lsu_req_ready", lsu_req_ready, 0);
    end
    nxt(); mem_mode = 0;
    k = 0;
    for (int c = 0; c < 20; c++) begin
      nxt();
      #3;
      if (lsu_req_ready) begin k = 1; break; end
    end
    chk("t5 lsu eventually granted", k, 1);
    idle(5);

    // Reset while waiting for a response.
    mem_mode = 2;
    nxt();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0080;
    #3 chk("t6 ifu_req_ready", ifu_req_ready, 1);
    nxt(); ifu_req_valid = 0;
    nxt(); rst = 1;
    nxt(); rst = 0;
    #3 chk("t6 busy", busy, 0);
    chk("t6 mem_req_valid", mem_req_valid, 0);
    chk("t6 mem_addr", mem_addr, 0);
    chk("t6 lsu_rdata", lsu_rdata, 0);
    chk("t6 mem_wdata", mem_wdata, 0);
    for (int c = 0; c < 3; c++) begin
      nxt();
      #3 chk("t6 no rsp", ifu_rsp_valid, 0);
    end
    mem_mode = 0; mem_fixed = 32'h55;
    nxt();
    ifu_req_valid = 1; ifu_addr = 32'h8000_0084;
    #3 chk("t6 ifu_req_ready again", ifu_req_ready, 1);
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      nxt(); ifu_req_valid = 0;
      #3;
      if (ifu_rsp_valid) begin k = c; break; end
    end
    chk("t6 latency", k, 3);
    chk("t6 ifu_rdata", ifu_rdata, 32'h55);
    idle(2);

    // Random traffic, then drain while honouring the hold-until-ready rule.
    mem_mode = 1;
    for (int c = 0; c < 2500; c++) begin
      nxt();
      drive_random(1'b1);
    end
    for (int c = 0; c < 300; c++) begin
      nxt();
      drive_random(1'b0);
      if (!ifu_req_valid && !lsu_req_valid && !m_active) break;
    end
    chk("drain idle", {30'd0, ifu_req_valid, lsu_req_valid}, 0);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
